// File: rtl/systolic_mac_ctrl.sv
// Sequencing controller for the 4x4 MAC array.
// Clears the accumulators, admits exactly len operand beats, then holds the result until acknowledged.
module systolic_mac_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             arr_en,
    output logic             arr_clr,
    output logic             busy,
    output logic [LEN_W-1:0] beats,
    output logic             res_valid,
    input  logic             res_ack
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beats_nxt;
    logic             beat_acc;

    // NOTE: in_ready depends on state only, so the source never sees a combinational loop through in_valid.
    assign in_ready  = (state == RUN);
    assign beat_acc  = in_ready & in_valid & ~abort;
    assign arr_en    = beat_acc;
    assign beats_nxt = beats + LEN_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            beats     <= '0;
            arr_clr   <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else if (abort) begin
            // beats is left alone so the abort point stays observable.
            state     <= IDLE;
            arr_clr   <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            arr_clr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        beats   <= '0;
                        arr_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (len_q != '0) begin
                        state <= RUN;
                    end else begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        beats <= beats_nxt;
                        if (beats_nxt == len_q) begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    state     <= DONE;
                    res_valid <= 1'b1;
                end
                DONE: begin
                    if (res_ack) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
